// File: rtl/tp_sync_rx.sv
// Two-phase dual-rail token receiver: synchronizes every rail, decodes against the last accepted token and presents the word on a valid/ready port.
// Optional macro TP_RX_ERR_EN enables the sticky double-rail protocol error flag; undefined ties err to 0.
module tp_sync_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0][1:0] in,
  output logic                  ack_o,
  output logic [WIDTH-1:0]      dat,
  output logic                  dat_valid,
  input  logic                  dat_ready,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                                 state;
  state_t                                 state_nxt;
  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0][1:0]                  sin;
  logic [WIDTH-1:0][1:0]                  sin_prev;
  logic [WIDTH-1:0][1:0]                  ref_q;
  logic [WIDTH-1:0]                       tog;
  logic [WIDTH-1:0]                       d;
  logic                                   complete;
  logic                                   stable;
  logic                                   free;
  logic                                   capture;

  assign sin = sync_q[SYNC_STAGES-1];

  // Synchronizer chain plus a one-cycle history of its output for the settle check.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= '0;
      sin_prev <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sin_prev <= sin;
    end
  end

  always_comb begin
    tog = '0;
    d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = (sin[i][1] ^ ref_q[i][1]) ^ (sin[i][0] ^ ref_q[i][0]);
      d[i]   = sin[i][1] ^ ref_q[i][1];
    end
  end

  assign complete = &tog;
  assign stable   = (sin == sin_prev);
  // Output port: a word transfers on any edge where dat_valid and dat_ready are both 1;
  // dat holds still while dat_valid=1 and dat_ready=0, and the register is free for a new
  // capture when it is empty or being consumed in the same cycle.
  assign free     = !dat_valid || dat_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: begin
        if (complete) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!complete)   state_nxt = S_WAIT;
        else if (stable) state_nxt = free ? S_WAIT : S_HOLD;
      end
      S_HOLD: begin
        if (!complete || free) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    state_dbg = state;
    case (state)
      S_SETTLE: capture = complete && stable && free;
      S_HOLD:   capture = complete && free;
      default:  capture = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q     <= '0;
      dat       <= '0;
      dat_valid <= 1'b0;
      ack_o     <= 1'b0;
    end else if (capture) begin
      ref_q     <= sin;
      dat       <= d;
      dat_valid <= 1'b1;
      ack_o     <= ~ack_o;
    end else if (dat_valid && dat_ready) begin
      dat_valid <= 1'b0;
    end
  end

`ifdef TP_RX_ERR_EN
  logic [WIDTH-1:0] dbl;

  always_comb begin
    dbl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dbl[i] = (sin[i][1] ^ ref_q[i][1]) & (sin[i][0] ^ ref_q[i][0]);
    end
  end

  // Both rails of a bit moving is illegal unless a token is mid-settle or being taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((|dbl) && !capture && (state != S_SETTLE)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tp_sync_rx.sv
// Bench for tp_sync_rx (WIDTH=4, SYNC_STAGES=2): a dual-rail sender model encodes words,
// a scoreboard queue holds the words expected at the output port in order.
module tb_tp_sync_rx;
  localparam int W = 4;
  localparam int S = 2;
`ifdef TP_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0][1:0] in;
  logic              ack_o;
  logic [W-1:0]      dat;
  logic              dat_valid;
  logic              dat_ready;
  logic              err;
  logic [1:0]        state_dbg;

  int                checks = 0;
  int                fails  = 0;
  logic [W-1:0]      exp_q[$];
  logic [W-1:0][1:0] rails;
  logic              ack_exp;
  logic [W-1:0]      prev_dat;
  bit                prev_hold = 1'b0;

  always #5 clk = ~clk;

  tp_sync_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .in(in), .ack_o(ack_o), .dat(dat),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .err(err), .state_dbg(state_dbg)
  );

  // Scoreboard: every transfer must deliver the oldest outstanding word; held data must not move.
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (rst !== 1'b1) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && dat_valid === 1'b1) begin
        checks++;
        if (dat !== prev_dat) begin
          fails++;
          $display("FAIL hold_stable: dat=%h want %h", dat, prev_dat);
        end
      end
      if (dat_valid === 1'b1 && dat_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: dat=%h delivered, want no transfer", dat);
        end else begin
          w = exp_q.pop_front();
          if (dat !== w) begin
            fails++;
            $display("FAIL sb_data: dat=%h want %h", dat, w);
          end
        end
      end
      prev_hold = (dat_valid === 1'b1) && (dat_ready === 1'b0);
      prev_dat  = dat;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) rails[i][w[i]] = ~rails[i][w[i]];
    in = rails;
    exp_q.push_back(w);
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    while (ack_o === ack_exp && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (ack_o === ack_exp) begin
      fails++;
      $display("FAIL %s: ack_o=%b after %0d cycles, want %b", name, ack_o, budget, ~ack_exp);
    end
    ack_exp = ~ack_exp;
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b0;
    rails = '0;
    in    = '0;
    step(n);
    exp_q.delete();
    ack_exp = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (ack_o !== 1'b0 || dat !== '0 || dat_valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: ack_o=%b dat=%h dat_valid=%b err=%b, want 0 0 0 0",
               name, ack_o, dat, dat_valid, err);
    end
  endtask

  task automatic test_reset();
    dat_ready = 1'b0;
    do_reset(3);
    check_idle("reset_values");
  endtask

  // Exact latency: rails settle before edge 1, output appears after edge S+2.
  task automatic test_latency(input string name, input logic [W-1:0] w);
    dat_ready = 1'b1;
    drive_word(w);
    step(S + 1);
    checks++;
    if (ack_o !== ack_exp || dat_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_early: ack_o=%b dat_valid=%b, want %b 0", name, ack_o, dat_valid, ack_exp);
    end
    step(1);
    checks++;
    if (ack_o !== ~ack_exp || dat_valid !== 1'b1 || dat !== w) begin
      fails++;
      $display("FAIL %s_capture: ack_o=%b dat_valid=%b dat=%h, want %b 1 %h",
               name, ack_o, dat_valid, dat, ~ack_exp, w);
    end
    ack_exp = ~ack_exp;
    step(1);
    checks++;
    if (dat_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse: dat_valid=%b, want 0", name, dat_valid);
    end
  endtask

  task automatic test_backpressure();
    logic a0;
    a0 = ack_o;
    dat_ready = 1'b0;
    drive_word(4'h1);
    wait_ack("bp_tok1", 40);
    drive_word(4'h2);
    step(12);
    checks++;
    if (ack_o !== ack_exp || dat !== 4'h1 || dat_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_defer2: ack_o=%b dat=%h dat_valid=%b, want %b 1 1", ack_o, dat, dat_valid, ack_exp);
    end
    dat_ready = 1'b1;
    step(1);
    dat_ready = 1'b0;
    checks++;
    if (ack_o !== ~ack_exp || dat !== 4'h2 || dat_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_swap2: ack_o=%b dat=%h dat_valid=%b, want %b 2 1", ack_o, dat, dat_valid, ~ack_exp);
    end
    ack_exp = ~ack_exp;
    drive_word(4'h3);
    step(12);
    checks++;
    if (ack_o !== a0 || dat !== 4'h2) begin
      fails++;
      $display("FAIL bp_two_acks: ack_o=%b dat=%h, want %b 2", ack_o, dat, a0);
    end
    dat_ready = 1'b1;
    step(1);
    checks++;
    if (ack_o !== ~ack_exp || dat !== 4'h3 || dat_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_swap3: ack_o=%b dat=%h dat_valid=%b, want %b 3 1", ack_o, dat, dat_valid, ~ack_exp);
    end
    ack_exp = ~ack_exp;
    step(1);
    checks++;
    if (dat_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: dat_valid=%b, want 0", dat_valid);
    end
  endtask

  task automatic test_skew();
    logic [W-1:0] w;
    int           off;
    int           idx;
    bit           bad;
    dat_ready = 1'b1;
    w   = W'($urandom_range(0, 15));
    off = $urandom_range(0, W - 1);
    exp_q.push_back(w);
    for (int i = 0; i < W; i++) begin
      idx = (i + off) % W;
      rails[idx][w[idx]] = ~rails[idx][w[idx]];
      in = rails;
      if (i < W - 1) begin
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
          step(1);
          if (dat_valid !== 1'b0 || ack_o !== ack_exp || err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
          fails++;
          $display("FAIL skew_partial_%0d: dat_valid=%b ack_o=%b err=%b, want 0 %b 0",
                   i, dat_valid, ack_o, err, ack_exp);
        end
      end
    end
    wait_ack("skew_capture", 40);
    step(2);
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL skew_err: err=%b, want 0", err);
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 20; t++) begin
      drive_word(W'($urandom_range(0, 15)));
      n = 0;
      while (ack_o === ack_exp && n < 100) begin
        dat_ready = 1'($urandom_range(0, 1));
        step(1);
        n++;
      end
      checks++;
      if (ack_o === ack_exp) begin
        fails++;
        $display("FAIL rand_ack_%0d: ack_o=%b, want %b", t, ack_o, ~ack_exp);
      end
      ack_exp = ~ack_exp;
      repeat ($urandom_range(0, 3)) begin
        dat_ready = 1'($urandom_range(0, 1));
        step(1);
      end
    end
    dat_ready = 1'b1;
    step(3);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    dat_ready = 1'b1;
    w = W'($urandom_range(0, 15));
    rails[0][w[0]] = ~rails[0][w[0]];
    rails[1][w[1]] = ~rails[1][w[1]];
    in = rails;
    step(6);
    checks++;
    if (ack_o !== ack_exp || dat_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_partial: ack_o=%b dat_valid=%b, want %b 0", ack_o, dat_valid, ack_exp);
    end
    do_reset(2);
    check_idle("mid_reset");
    test_latency("mid_after", W'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_hold();
    dat_ready = 1'b0;
    drive_word(W'($urandom_range(0, 15)));
    wait_ack("hold_tok1", 40);
    drive_word(W'($urandom_range(0, 15)));
    step(8);
    do_reset(2);
    check_idle("hold_reset");
    dat_ready = 1'b1;
    drive_word(W'($urandom_range(0, 15)));
    wait_ack("hold_after", 40);
    step(2);
  endtask

  task automatic test_err();
    dat_ready = 1'b1;
    rails[0] = ~rails[0];
    in = rails;
    step(8);
    checks++;
    if (err !== ERR_EN || ack_o !== ack_exp) begin
      fails++;
      $display("FAIL err_set: err=%b ack_o=%b, want %b %b", err, ack_o, ERR_EN, ack_exp);
    end
    rails[0] = ~rails[0];
    in = rails;
    step(10);
    checks++;
    if (err !== ERR_EN) begin
      fails++;
      $display("FAIL err_sticky: err=%b, want %b", err, ERR_EN);
    end
    do_reset(2);
    check_idle("err_reset");
  endtask

  initial begin
    rst       = 1'b0;
    in        = '0;
    rails     = '0;
    dat_ready = 1'b0;
    ack_exp   = 1'b0;
    test_reset();
    test_latency("first", 4'hA);
    test_latency("second", 4'h5);
    test_backpressure();
    test_skew();
    test_random();
    test_reset_mid();
    test_reset_hold();
    test_err();
    test_latency("final", 4'hC);
    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d words undelivered, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
